instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory interface: owns the PC, drives the word address into
//  instr_rom, captures the returned instruction into the IF/ID pipeline register and applies
//  stall, jump (ID) and taken-branch (EX) redirects. It is the fetch stage of the pipelined core.
// PARAMETERS
//  N        32  datapath/instruction width; also the imem address width
//  DEPTH    32  instruction memory words; legal PC range 0..DEPTH-1
//  RESET_PC 0   word index fetched first after reset
// PORTS
//  clk            in  1   rising-edge clock
//  rst_n          in  1   asynchronous, active-low reset
//  imem_addr      out N   word index to instr_rom (= pc, zero-extended)
//  imem_instr     in  N   instruction for imem_addr, combinational, valid in the same cycle
//  stall          in  1   hazard stall from ID: hold PC and IF/ID
//  jump_valid     in  1   ID decoded a jump (opcode 2) this cycle
//  jump_index     in  26  jump word-index field
//  br_valid       in  1   EX resolved a taken beq this cycle
//  br_target      in  N   branch target word index (pc_plus1 + sign-extended imm)
//  if_id_valid    out 1   IF/ID register holds a real instruction
//  if_id_instr    out N   captured instruction
//  if_id_pc_plus1 out N   word index of captured instruction + 1
//  id_flush       out 1   registered pulse: ID/EX must insert a bubble (taken branch)
//  halted         out 1   fetch stopped on out-of-range PC
// BEHAVIOUR
//  - Reset (async, any cycle, also mid-operation): pc=RESET_PC, state=BOOT, if_id_valid=0,
//    if_id_instr=0, if_id_pc_plus1=0, id_flush=0, halted=0. imem_addr follows pc immediately.
//  - States: BOOT -> RUN on the first edge after reset release (one bubble, no capture);
//    RUN -> HALT when next-PC >= DEPTH; HALT -> RUN when br_valid/jump_valid gives in-range target.
//  - Latency: instruction at imem_addr in cycle t is in if_id_* after edge t+1.
//  - Next-PC priority per edge (RUN): br_valid > jump_valid > stall > pc+1.
//    br_valid : pc<=br_target; if_id_valid<=0; id_flush<=1 (ID instr is wrong path).
//    jump_valid: pc<={pc_plus1[N-1:26], jump_index}; if_id_valid<=0; id_flush<=0.
//    stall    : pc and all if_id_* hold; id_flush<=0.
//    else     : pc<=pc+1; if_id_instr<=imem_instr; if_id_pc_plus1<=pc+1; if_id_valid<=1.
//  - br_valid with stall or jump_valid in the same cycle: branch wins, stall ignored that edge.
//  - id_flush is a one-cycle pulse; it never stays high two consecutive cycles without br_valid.
//  - Out of range: sequential next-PC == DEPTH, or redirect target >= DEPTH -> pc holds last
//    legal value, if_id_valid<=0, halted<=1, state HALT. The last legal instruction (DEPTH-1)
//    is still captured when reached sequentially. No wrap-around to 0.
//  - HALT: stall ignored, if_id_valid stays 0; in-range redirect sets pc, clears halted, RUN.
//  - Arithmetic: all PC math N-bit unsigned, carry discarded; targets compared to DEPTH unsigned.
// STRUCTURE
//  - Shared package: fetch state enum {BOOT,RUN,HALT}, OP_J=6'd2, OP_BEQ=6'd4, NOP=32'h0,
//    JIDX_W=26.
//  - One sub-module: if_id_reg (valid/instr/pc_plus1 with hold and clear), async active-low reset.
//  - Next-PC mux, range check and FSM stay in instr_fetch_unit.
// TESTING
//  - Reset: rst_n=0 -> imem_addr=0, if_id_valid=0, halted=0; release -> one bubble, then 0,1,2.
//  - Sequential: 4 free cycles -> if_id_pc_plus1 = 1,2,3,4, if_id_instr matches ROM words 0..3.
//  - Stall at pc=3 for 2 cycles -> imem_addr stays 3, if_id_* unchanged, resumes with 4.
//  - jump_valid, jump_index=16 at pc=6 -> next imem_addr=16, if_id_valid=0 one cycle, id_flush=0.
//  - br_valid, br_target=6 with jump_valid+stall same cycle -> imem_addr=6, id_flush=1 one cycle.
//  - Run to pc=31 -> word 31 captured, then halted=1, if_id_valid=0; br_target=40 stays halted;
//    br_target=0 -> RUN; assert rst_n=0 mid-run -> all outputs return to reset values at once.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module : instr_fetch_unit_pkg
// Brief  : Shared types and constants for the instruction fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

  // Fetch sequencing: one bubble after reset, normal fetch, stopped on bad PC
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Opcodes the surrounding core decodes into jump_valid / br_valid
  localparam logic [5:0]  OP_J   = 6'd2;
  localparam logic [5:0]  OP_BEQ = 6'd4;

  // Value held by the IF/ID instruction field when it carries nothing
  localparam logic [31:0] NOP    = 32'h0;

  // Width of the jump word-index field
  localparam int          JIDX_W = 26;

endpackage : instr_fetch_unit_pkg

`default_nettype wire

// File: rtl/instr_fetch_unit_if_id_reg.sv
// ============================================================================
// Module : instr_fetch_unit_if_id_reg
// Brief  : IF/ID pipeline register (valid, instruction, pc+1) with load,
//          valid-clear and hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit_if_id_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [N-1:0] instr_in,
  input  logic [N-1:0] pc_plus1_in,
  output logic         valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] pc_plus1
);

  // Load wins over clear; with neither asserted the register holds (stall).
  // Clearing only drops valid so the stale payload stays visible for debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= N'(NOP);
      pc_plus1 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      pc_plus1 <= pc_plus1_in;
    end else if (clear) begin
      valid    <= 1'b0;
    end
  end

endmodule : instr_fetch_unit_if_id_reg

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Fetch stage. Owns the PC, addresses instruction memory, fills the
//          IF/ID register and applies stall, jump and taken-branch redirects.
//          Stops (HALT) rather than wrapping when the PC leaves 0..DEPTH-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int N        = 32,
  parameter int DEPTH    = 32,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  input  logic         stall,
  input  logic         jump_valid,
  input  logic [25:0]  jump_index,
  input  logic         br_valid,
  input  logic [N-1:0] br_target,
  output logic         if_id_valid,
  output logic [N-1:0] if_id_instr,
  output logic [N-1:0] if_id_pc_plus1,
  output logic         id_flush,
  output logic         halted
);

  localparam logic [N-1:0] DEPTH_N    = N'(DEPTH);
  localparam logic [N-1:0] RESET_PC_N = N'(RESET_PC);

  fetch_state_t state;
  fetch_state_t next_state;

  logic [N-1:0] pc;
  logic [N-1:0] pc_plus1;
  logic [N-1:0] jump_target;
  logic [N-1:0] next_pc;
  logic         next_flush;
  logic         next_halted;
  logic         ifid_load;
  logic         ifid_clear;
  logic         br_in_range;
  logic         jump_in_range;
  logic         seq_in_range;

  assign imem_addr     = pc;
  assign pc_plus1      = pc + 1'b1;
  assign br_in_range   = (br_target   < DEPTH_N);
  assign jump_in_range = (jump_target < DEPTH_N);
  assign seq_in_range  = (pc_plus1    < DEPTH_N);

  // Jump target keeps the upper bits of pc+1 above the index field
  generate
    if (N > JIDX_W) begin : g_jump_wide
      assign jump_target = {pc_plus1[N-1:JIDX_W], jump_index};
    end else begin : g_jump_narrow
      assign jump_target = jump_index[N-1:0];
    end
  endgenerate

  // Next-PC selection, range check and FSM transitions.
  // Priority in RUN: branch > jump > stall > sequential.
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    next_flush  = 1'b0;
    next_halted = halted;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;
    case (state)
      BOOT: begin
        // One bubble: memory is addressed but nothing is captured
        next_state = RUN;
        ifid_clear = 1'b1;
      end
      RUN: begin
        if (br_valid) begin
          // Instruction in ID came from the wrong path
          ifid_clear = 1'b1;
          next_flush = 1'b1;
          if (br_in_range) begin
            next_pc = br_target;
          end else begin
            next_halted = 1'b1;
            next_state  = HALT;
          end
        end else if (jump_valid) begin
          ifid_clear = 1'b1;
          if (jump_in_range) begin
            next_pc = jump_target;
          end else begin
            next_halted = 1'b1;
            next_state  = HALT;
          end
        end else if (!stall) begin
          // Current word is always captured, even the last legal one
          ifid_load = 1'b1;
          if (seq_in_range) begin
            next_pc = pc_plus1;
          end else begin
            next_halted = 1'b1;
            next_state  = HALT;
          end
        end
      end
      HALT: begin
        // Stall is irrelevant here; only an in-range redirect restarts fetch
        ifid_clear = 1'b1;
        if (br_valid) begin
          if (br_in_range) begin
            next_pc     = br_target;
            next_halted = 1'b0;
            next_state  = RUN;
          end
        end else if (jump_valid) begin
          if (jump_in_range) begin
            next_pc     = jump_target;
            next_halted = 1'b0;
            next_state  = RUN;
          end
        end
      end
      default: begin
        next_state = BOOT;
        ifid_clear = 1'b1;
      end
    endcase
  end

  // State, PC and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC_N;
      id_flush <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= next_pc;
      id_flush <= next_flush;
      halted   <= next_halted;
    end
  end

  instr_fetch_unit_if_id_reg #(
    .N (N)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ifid_load),
    .clear       (ifid_clear),
    .instr_in    (imem_instr),
    .pc_plus1_in (pc_plus1),
    .valid       (if_id_valid),
    .instr       (if_id_instr),
    .pc_plus1    (if_id_pc_plus1)
  );

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Scoreboard bench for instr_fetch_unit with a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        jump_valid;
  logic [25:0] jump_index;
  logic        br_valid;
  logic [31:0] br_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus1;
  logic        id_flush;
  logic        halted;

  logic [31:0] rom [DEPTH];

  instr_fetch_unit #(
    .N        (32),
    .DEPTH    (DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .jump_valid     (jump_valid),
    .jump_index     (jump_index),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .id_flush       (id_flush),
    .halted         (halted)
  );

  assign imem_instr = (imem_addr < DEPTH) ? rom[imem_addr[4:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pp1;
    logic        flush;
    logic        halted;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all(input exp_t e);
    check("imem_addr",      imem_addr,             e.addr);
    check("if_id_valid",    {31'b0, if_id_valid},  {31'b0, e.valid});
    check("if_id_pc_plus1", if_id_pc_plus1,        e.pp1);
    check("id_flush",       {31'b0, id_flush},     {31'b0, e.flush});
    check("halted",         {31'b0, halted},       {31'b0, e.halted});
    // Instruction payload is only meaningful while valid
    if (e.valid) check("if_id_instr", if_id_instr, e.instr);
  endtask

  // Monitor: one expected snapshot per clock, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      compare_all(mon_e);
    end
  end

  // ---------------- reference model ----------------
  // mode: 0 = just out of reset, 1 = fetching, 2 = stopped
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pp1;
  logic        m_valid, m_flush, m_halt;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = 0; m_pp1 = 0;
    m_valid = 0; m_flush = 0; m_halt = 0;
  endtask

  task automatic stop_fetch();
    m_halt = 1;
    m_mode = 2;
  endtask

  task automatic model_step(input bit br, input logic [31:0] bt, input bit j,
                            input logic [25:0] ji, input bit st);
    logic [31:0] seq;
    logic [31:0] jt;
    seq = m_pc + 1;
    jt  = {seq[31:26], ji};
    m_flush = 0;
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (br) begin
        m_valid = 0;
        m_flush = 1;
        if (bt < DEPTH) m_pc = bt; else stop_fetch();
      end else if (j) begin
        m_valid = 0;
        if (jt < DEPTH) m_pc = jt; else stop_fetch();
      end else if (!st) begin
        m_instr = rom[m_pc[4:0]];
        m_pp1   = seq;
        m_valid = 1;
        if (seq < DEPTH) m_pc = seq; else stop_fetch();
      end
    end else begin
      m_valid = 0;
      if (br) begin
        if (bt < DEPTH) begin m_pc = bt; m_halt = 0; m_mode = 1; end
      end else if (j) begin
        if (jt < DEPTH) begin m_pc = jt; m_halt = 0; m_mode = 1; end
      end
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.addr = m_pc; e.valid = m_valid; e.instr = m_instr;
    e.pp1 = m_pp1; e.flush = m_flush; e.halted = m_halt;
    return e;
  endfunction

  // Drive one clock of stimulus; expectation is queued after the edge
  task automatic cycle(input bit br, input logic [31:0] bt, input bit j,
                       input logic [25:0] ji, input bit st);
    br_valid = br; br_target = bt; jump_valid = j; jump_index = ji; stall = st;
    if (rst_n) model_step(br, bt, j, ji, st);
    @(posedge clk);
    q.push_back(model_snapshot());
    #1;
  endtask

  task automatic free_run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rst_n = 0; stall = 0; jump_valid = 0; jump_index = 0; br_valid = 0; br_target = 0;
    model_reset();
    #2;
    compare_all(model_snapshot());

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    rst_n = 1;

    cycle(0, 0, 0, 0, 0);          // bubble after reset
    free_run(3);                   // capture words 0..2, pc = 3
    cycle(0, 0, 0, 0, 1);          // stall at pc = 3
    cycle(0, 0, 0, 0, 1);
    free_run(3);                   // words 3..5, pc = 6
    cycle(0, 0, 1, 26'd16, 0);     // jump to 16
    free_run(2);
    cycle(1, 32'd6, 1, 26'd20, 1); // branch beats jump and stall
    free_run(2);
    cycle(0, 0, 1, 26'd40, 0);     // out-of-range jump halts
    cycle(0, 0, 0, 0, 1);          // stall ignored while halted
    cycle(1, 32'd0, 0, 0, 0);      // restart at 0
    free_run(34);                  // run off the end at 31
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'd40, 0, 0, 0);     // out-of-range branch keeps halted
    cycle(1, 32'd0, 0, 0, 0);      // back to RUN
    free_run(5);

    // Asynchronous reset mid-run, checked between edges
    @(negedge clk); #1;
    rst_n = 0;
    model_reset();
    #1;
    compare_all(model_snapshot());
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'd5, 0, 0, 0);
    rst_n = 1;
    free_run(3);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cycle(r < 8, 32'($urandom_range(0, 40)),
            (r >= 8) && (r < 16), 26'($urandom_range(0, 40)),
            (r >= 16) && (r < 32));
    end

    br_valid = 0; jump_valid = 0; stall = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit

`default_nettype wire
